// File: rtl/dma_bench_rr_arbiter_pkg.sv
// Shared types and field offsets for the DMA benchmark round-robin arbiter.
// Optional source stamping is enabled by DMA_ARB_SRC_STAMP_EN.
package dma_bench_rr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int GRANT_W       = 2;
    localparam int SRC0          = 0;
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_W   = 16;
    localparam int TUSER_SRC_LSB = 16;
    localparam int TUSER_SRC_W   = 8;

    // CPU0..3 map to one-hot bits 1,3,5,7 of the tuser source field
    function automatic logic [TUSER_SRC_W-1:0] src_stamp(
        input logic [GRANT_W-1:0] g
    );
        return 8'b1 << {g, 1'b1};
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first request at or after the pointer.
// Shared by the arbiter and future schedulers.
module rr_priority_pick
    import dma_bench_rr_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GRANT_W-1:0]   i_ptr,
    output logic [GRANT_W-1:0]   o_grant,
    output logic                 o_found
);

    // Walk offsets high to low so the smallest offset overwrites last
    always_comb begin
        o_grant = i_ptr;
        o_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % NUM_PORTS]) begin
                o_grant = GRANT_W'((int'(i_ptr) + i) % NUM_PORTS);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_bench_rr_arbiter.sv
// Packet-level round-robin merge of per-CPU DMA AXI-Stream queues.
// Define DMA_ARB_SRC_STAMP_EN to overwrite tuser[23:16] with a one-hot source.
module dma_bench_rr_arbiter
    import dma_bench_rr_arbiter_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH = 256,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int C_AXIS_TUSER_WIDTH  = 128,
    parameter int NUM_PORTS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   RESET,
    input  logic [NUM_PORTS-1:0]                   port_en,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
    input  logic [NUM_PORTS-1:0]                   S_AXIS_TVALID,
    input  logic [NUM_PORTS-1:0]                   S_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]                   S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
    output logic [C_AXIS_TUSER_WIDTH-1:0]          M_AXIS_TUSER,
    output logic                                   M_AXIS_TLAST,
    output logic                                   M_AXIS_TVALID,
    input  logic                                   M_AXIS_TREADY,
    output logic                                   arb_busy,
    output logic [GRANT_W-1:0]                     arb_grant,
    output logic [31:0]                            arb_pkt_total
);

    localparam int SW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [GRANT_W-1:0] w_ptr_nxt;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] w_grant_nxt;
    logic [31:0]        r_pkt_total;
    logic [31:0]        w_total_nxt;
    logic [NUM_PORTS-1:0] w_req;
    logic [GRANT_W-1:0] w_pick;
    logic               w_found;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_last_fire;

    assign w_req = S_AXIS_TVALID & port_en;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_found (w_found)
    );

    assign w_sel_valid = S_AXIS_TVALID[int'(r_grant)];
    assign w_sel_last  = S_AXIS_TLAST[int'(r_grant)];
    assign w_last_fire = (r_state == ARB_BUSY) && w_sel_valid
                         && M_AXIS_TREADY && w_sel_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_total_nxt   = r_pkt_total;
        M_AXIS_TDATA  = '0;
        M_AXIS_TSTRB  = '0;
        M_AXIS_TUSER  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = '0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            ARB_BUSY: begin
                M_AXIS_TDATA  = S_AXIS_TDATA[int'(r_grant)*SW +: SW];
                M_AXIS_TSTRB  = S_AXIS_TSTRB[int'(r_grant)*KW +: KW];
                M_AXIS_TUSER  = S_AXIS_TUSER[int'(r_grant)*UW +: UW];
`ifdef DMA_ARB_SRC_STAMP_EN
                M_AXIS_TUSER[TUSER_SRC_LSB +: TUSER_SRC_W] = src_stamp(r_grant);
`endif
                M_AXIS_TLAST  = w_sel_last;
                M_AXIS_TVALID = w_sel_valid;
                S_AXIS_TREADY[int'(r_grant)] = M_AXIS_TREADY;
                if (w_last_fire) begin
                    w_state_nxt = ARB_IDLE;
                    w_total_nxt = r_pkt_total + 32'd1;
                    w_ptr_nxt   = (r_grant == GRANT_W'(NUM_PORTS - 1))
                                  ? '0 : r_grant + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= GRANT_W'(SRC0);
            r_pkt_total <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_pkt_total <= w_total_nxt;
        end
    end

    assign arb_busy      = (r_state == ARB_BUSY);
    assign arb_grant     = r_grant;
    assign arb_pkt_total = r_pkt_total;

endmodule

// File: tb/tb_dma_bench_rr_arbiter.sv
// Directed bench for dma_bench_rr_arbiter with per-port packet sources.
// Expected beats are encoded as {port, packet, beat} in tdata[23:0].
module tb_dma_bench_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    logic              ACLK = 1'b0;
    logic              RESET;
    logic [N-1:0]      port_en;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tstrb;
    logic [N*UW-1:0]   s_tuser;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic              arb_busy;
    logic [1:0]        arb_grant;
    logic [31:0]       arb_pkt_total;

    int errors = 0;
    int checks = 0;
    int nlast  = 0;

    int src_len [N];
    int src_npkt[N];
    int src_beat[N];
    int src_pkt [N];
    bit src_hold[N];
    bit src_clr;

    always #5 ACLK = ~ACLK;

    dma_bench_rr_arbiter dut (
        .ACLK          (ACLK),
        .RESET         (RESET),
        .port_en       (port_en),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TREADY (m_tready),
        .arb_busy      (arb_busy),
        .arb_grant     (arb_grant),
        .arb_pkt_total (arb_pkt_total)
    );

    always_comb begin
        s_tdata  = '0;
        s_tuser  = '0;
        s_tstrb  = '1;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int p = 0; p < N; p++) begin
            s_tvalid[p] = (src_pkt[p] < src_npkt[p]) && !src_hold[p];
            s_tlast[p]  = (src_beat[p] == src_len[p] - 1);
            s_tdata[p*DW +: 24] = {8'(p), 8'(src_pkt[p]), 8'(src_beat[p])};
            s_tuser[p*UW +: 24] = {8'(8'hA0 + p), 16'(src_len[p])};
        end
    end

    always @(posedge ACLK) begin
        for (int p = 0; p < N; p++) begin
            if (src_clr) begin
                src_beat[p] <= 0;
                src_pkt[p]  <= 0;
            end else if (s_tvalid[p] && s_tready[p]) begin
                if (s_tlast[p]) begin
                    src_beat[p] <= 0;
                    src_pkt[p]  <= src_pkt[p] + 1;
                end else begin
                    src_beat[p] <= src_beat[p] + 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int p, input int k,
                            input int b, input bit l);
        chk(tag, {m_tvalid, m_tlast, arb_grant, m_tdata[23:0]},
            {1'b1, l, 2'(p), 8'(p), 8'(k), 8'(b)});
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {m_tvalid, arb_busy, s_tready}, '0);
    endtask

    task automatic do_reset;
        RESET   = 1'b1;
        src_clr = 1'b1;
        port_en = '0;
        m_tready = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_npkt[p] = 0;
            src_hold[p] = 1'b0;
        end
        tick;
        tick;
        RESET   = 1'b0;
        src_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_src;
        int p;
        int k;

        RESET    = 1'b1;
        src_clr  = 1'b1;
        port_en  = '0;
        m_tready = 1'b1;
        tick;
        tick;
        chk("reset_state",
            {m_tvalid, arb_busy, arb_grant, s_tready, arb_pkt_total}, '0);
        RESET   = 1'b0;
        src_clr = 1'b0;

        // single port, 3-beat packet
        port_en     = 4'b0001;
        src_len[0]  = 3;
        src_npkt[0] = 1;
        #1;
        chk_idle("t1_first_idle");
        tick;
        chk_beat("t1_b0", 0, 0, 0, 1'b0);
        chk("t1_rdy", s_tready, 4'b0001);
        chk("t1_strb", m_tstrb, 32'hFFFF_FFFF);
        tick;
        chk_beat("t1_b1", 0, 0, 1, 1'b0);
        tick;
        chk_beat("t1_b2", 0, 0, 2, 1'b1);
        tick;
        chk_idle("t1_after");
        chk("t1_total", arb_pkt_total, 1);

        // pointer now at 1: port 1 wins over port 0, single-beat packets
        port_en     = 4'b0011;
        src_len[0]  = 1;
        src_npkt[0] = 2;
        src_len[1]  = 1;
        src_npkt[1] = 1;
        #1;
        tick;
        chk_beat("t1_ptr_p1", 1, 0, 0, 1'b1);
        tick;
        chk_idle("t1_ptr_gap");
        tick;
        chk_beat("t1_ptr_p0", 0, 1, 0, 1'b1);
        tick;
        chk("t1_total3", arb_pkt_total, 3);

        // all ports busy with 2-beat packets
        do_reset;
        port_en = 4'b1111;
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 2;
            src_npkt[i] = 2;
        end
        #1;
        for (int i = 0; i < 8; i++) begin
            p = i % 4;
            k = i / 4;
            chk_idle("t2_gap");
            tick;
            chk_beat("t2_b0", p, k, 0, 1'b0);
            tick;
            chk_beat("t2_b1", p, k, 1, 1'b1);
            tick;
        end
        chk("t2_total", arb_pkt_total, 8);

        // enable mask 1010
        do_reset;
        port_en = 4'b1010;
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 2;
            src_npkt[i] = 2;
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            p = (i % 2 == 0) ? 1 : 3;
            k = i / 2;
            tick;
            chk_beat("t3_b0", p, k, 0, 1'b0);
            chk("t3_rdy_mask", s_tready & 4'b0101, '0);
            tick;
            chk_beat("t3_b1", p, k, 1, 1'b1);
            chk("t3_rdy_mask", s_tready & 4'b0101, '0);
            tick;
        end
        chk_idle("t3_masked_a");
        tick;
        chk_idle("t3_masked_b");
        chk("t3_total", arb_pkt_total, 4);

        // granted source stalls mid-packet while another port waits
        do_reset;
        port_en     = 4'b1111;
        src_len[2]  = 4;
        src_npkt[2] = 1;
        #1;
        tick;
        chk_beat("t4_b0", 2, 0, 0, 1'b0);
        src_len[0]  = 2;
        src_npkt[0] = 1;
        tick;
        src_hold[2] = 1'b1;
        #1;
        for (int h = 0; h < 3; h++) begin
            chk("t4_hold", {m_tvalid, arb_busy, arb_grant}, {1'b0, 1'b1, 2'd2});
            if (h < 2) begin
                tick;
            end
        end
        src_hold[2] = 1'b0;
        #1;
        chk_beat("t4_b1", 2, 0, 1, 1'b0);
        tick;
        chk_beat("t4_b2", 2, 0, 2, 1'b0);
        tick;
        chk_beat("t4_b3", 2, 0, 3, 1'b1);
        tick;
        chk_idle("t4_gap");
        tick;
        chk_beat("t4_p0_b0", 0, 0, 0, 1'b0);
        tick;
        chk_beat("t4_p0_b1", 0, 0, 1, 1'b1);
        tick;
        chk("t4_total", arb_pkt_total, 2);

        // downstream ready toggles every cycle
        do_reset;
        port_en     = 4'b0010;
        src_len[1]  = 4;
        src_npkt[1] = 1;
        #1;
        tick;
        for (int i = 0; i < 8; i++) begin
            m_tready = (i % 2 == 1);
            #1;
            chk_beat("t5_beat", 1, 0, i / 2, (i / 2 == 3));
            chk("t5_rdy", s_tready, {2'b00, m_tready, 1'b0});
            if (m_tvalid && m_tready && m_tlast) begin
                nlast++;
            end
            tick;
        end
        m_tready = 1'b1;
        chk("t5_tlast_once", nlast, 1);
        chk("t5_total", arb_pkt_total, 1);
        chk_idle("t5_after");

        // port 3 tuser and reset mid-packet
`ifdef DMA_ARB_SRC_STAMP_EN
        exp_src = 8'h80;
`else
        exp_src = 8'hA3;
`endif
        port_en     = 4'b1000;
        src_len[3]  = 4;
        src_npkt[3] = 1;
        #1;
        tick;
        chk_beat("t6_b0", 3, 0, 0, 1'b0);
        chk("t6_tuser", m_tuser[23:0], {exp_src, 16'd4});
        tick;
        chk_beat("t6_b1", 3, 0, 1, 1'b0);
        RESET       = 1'b1;
        src_clr     = 1'b1;
        src_npkt[3] = 0;
        tick;
        chk("t6_reset_mid",
            {m_tvalid, m_tlast, arb_busy, arb_grant, s_tready, arb_pkt_total,
             m_tdata[31:0], m_tuser[31:0]}, '0);
        RESET   = 1'b0;
        src_clr = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
